// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: RAM word, RAM handshake status, arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_t;

  // Request captured at grant and replayed to RAM until it resolves.
  typedef struct packed {
    word_t addr;
    word_t store;
    logic  wen;
  } arb_req_t;

  localparam int WDOG_W = 8;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating stall counter; flags the cycle whose stall would reach TIMEOUT.
module arb_watchdog
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] count;

  // The stall counted this cycle is the one that reaches the limit.
  assign expired = enable && (({1'b0, count} + 9'd1) >= {1'b0, LIMIT});

  // Clear on grant, count stalled cycles, hold at the limit rather than wrap.
  always_ff @(posedge CLK) begin
    if (!nRST)                        count <= '0;
    else if (clear)                   count <= '0;
    else if (enable && count != LIMIT) count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data caches.
// One transaction in flight; data wins ties unless the previous winner was data.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output word_t     iload,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      timeout_err
);

  arb_state_t state, state_n;
  arb_req_t   lat, lat_n;
  logic       last_was_data, last_was_data_n;
  word_t      iload_r, dload_r;
  logic       dreq, dcomp, icomp, held, wd_expired, abort;

  assign dreq  = dREN | dWEN;
  assign dcomp = (state == DATA)  && dreq && (ramstate == ACCESS);
  assign icomp = (state == INSTR) && iREN && (ramstate == ACCESS);
  // Owner still asking; a dropped request ends the transaction without completion.
  assign held  = ((state == DATA) && dreq) || ((state == INSTR) && iREN);
  assign abort = held && wd_expired;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state == IDLE),
    .enable  ((state != IDLE) && (ramstate != ACCESS)),
    .expired (wd_expired)
  );

  // Next-state: grant in IDLE, otherwise leave on drop, completion or watchdog.
  always_comb begin
    state_n         = state;
    lat_n           = lat;
    last_was_data_n = last_was_data;
    case (state)
      IDLE: begin
        if (dreq && !(last_was_data && iREN)) begin
          state_n = DATA;
          lat_n   = '{addr: daddr, store: dstore, wen: dWEN};
        end else if (iREN) begin
          state_n   = INSTR;
          lat_n.addr = iaddr;
          lat_n.wen  = 1'b0;
        end
      end
      DATA, INSTR: begin
        if (!held) begin
          state_n = IDLE;
        end else if (dcomp || icomp) begin
          state_n         = IDLE;
          last_was_data_n = (state == DATA);
        end else if (wd_expired) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM port replays the latched request only while a transaction is open.
  always_comb begin
    ramREN   = (state == INSTR) || ((state == DATA) && !lat.wen);
    ramWEN   = (state == DATA) && lat.wen;
    ramaddr  = lat.addr;
    ramstore = lat.store;
    iwait    = iREN && !icomp;
    dwait    = dreq && !dcomp;
    iload    = icomp ? ramload : iload_r;
    dload    = dcomp ? ramload : dload_r;
  end

  // State, latched request, held load data and sticky abort flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= IDLE;
      lat           <= '0;
      last_was_data <= 1'b0;
      iload_r       <= '0;
      dload_r       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      lat           <= lat_n;
      last_was_data <= last_was_data_n;
      if (icomp) iload_r <= ramload;
      if (dcomp) dload_r <= ramload;
      if (abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, random vs model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  logic      CLK = 1'b0, nRST = 1'b0;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      iwait, dwait, ramREN, ramWEN, timeout_err;
  word_t     iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .iload(iload), .dwait(dwait),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .timeout_err(timeout_err)
  );

  int checks = 0, errors = 0;

  typedef struct packed {
    logic iw, dw, ren, wen;
    word_t addr, store, il, dl;
    logic terr;
  } obs_t;

  typedef struct {
    logic nrst, iren, dren, dwen;
    word_t ia, da, ds, rl;
    ramstate_t rs;
    obs_t exp;
  } vec_t;

  // Transaction-level reference: who owns RAM, what was captured, how long it stalled.
  int    m_own;   // 0 none, 1 data, 2 instr
  int    m_stall;
  bit    m_lwd, m_w, m_terr;
  word_t m_a, m_s, m_il, m_dl;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic obs_t actual();
    return '{iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, timeout_err};
  endfunction

  function automatic obs_t model_out();
    logic dq, dc, ic;
    dq = dREN | dWEN;
    dc = (m_own == 1) && dq && (ramstate == ACCESS);
    ic = (m_own == 2) && iREN && (ramstate == ACCESS);
    return '{iREN && !ic, dq && !dc, (m_own == 2) || (m_own == 1 && !m_w),
             (m_own == 1) && m_w, m_a, m_s, ic ? ramload : m_il, dc ? ramload : m_dl, m_terr};
  endfunction

  task automatic model_step();
    logic dq, hold;
    dq = dREN | dWEN;
    if (!nRST) begin
      m_own = 0; m_stall = 0; m_lwd = 0; m_w = 0; m_terr = 0;
      m_a = '0; m_s = '0; m_il = '0; m_dl = '0;
    end else if (m_own == 0) begin
      m_stall = 0;
      if (dq && !(m_lwd && iREN)) begin
        m_own = 1; m_a = daddr; m_s = dstore; m_w = dWEN;
      end else if (iREN) begin
        m_own = 2; m_a = iaddr; m_w = 0;
      end
    end else begin
      hold = (m_own == 1) ? dq : iREN;
      if (!hold) m_own = 0;
      else if (ramstate == ACCESS) begin
        if (m_own == 1) m_dl = ramload; else m_il = ramload;
        m_lwd = (m_own == 1);
        m_own = 0;
      end else begin
        m_stall++;
        if (m_stall >= TO) begin
          m_own = 0; m_terr = 1;
        end
      end
    end
  endtask

  // One clock: compare against model, advance model, wait for next drive point.
  task automatic tick();
    #1;
    chk("model", 200'(actual()), 200'(model_out()));
    model_step();
    @(negedge CLK);
  endtask

  task automatic reset_cycle();
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    tick();
    nRST = 1;
  endtask

  function automatic vec_t row(logic nr, logic ir, logic dr, logic dw, word_t ia, word_t da,
                               word_t ds, word_t rl, ramstate_t rs, obs_t e);
    vec_t v;
    v.nrst = nr; v.iren = ir; v.dren = dr; v.dwen = dw;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs; v.exp = e;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    int n;
    logic dtype;
    obs_t z;
    z = '0;

    // Bring DUT and model into reset together (DUT state is unknown before the first edge).
    nRST = 0;
    @(negedge CLK);
    model_step();

    // exp fields: iw dw ren wen addr store il dl terr
    tbl[0]  = row(0,0,0,0, 32'h0, 32'h0,   32'h0,         32'h0,         FREE,   z);
    tbl[1]  = row(1,1,0,0, 32'h40,32'h0,   32'h0,         32'h0,         FREE,   '{1,0,0,0,32'h0, 32'h0,32'h0,32'h0,0});
    tbl[2]  = row(1,1,0,0, 32'h40,32'h0,   32'h0,         32'h0,         BUSY,   '{1,0,1,0,32'h40,32'h0,32'h0,32'h0,0});
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = row(1,1,0,0, 32'h40,32'h0,   32'h0,         32'h2002_0001, ACCESS, '{0,0,1,0,32'h40,32'h0,32'h2002_0001,32'h0,0});
    tbl[6]  = row(1,0,0,0, 32'h40,32'h0,   32'h0,         32'h0,         FREE,   '{0,0,0,0,32'h40,32'h0,32'h2002_0001,32'h0,0});
    tbl[7]  = row(1,1,1,1, 32'h40,32'h100, 32'hDEAD_BEEF, 32'h0,         FREE,   '{1,1,0,0,32'h40,32'h0,32'h2002_0001,32'h0,0});
    tbl[8]  = row(1,1,1,1, 32'h40,32'h100, 32'hDEAD_BEEF, 32'h11,        ACCESS, '{1,0,0,1,32'h100,32'hDEAD_BEEF,32'h2002_0001,32'h11,0});
    tbl[9]  = row(1,1,1,0, 32'h40,32'h100, 32'hDEAD_BEEF, 32'h0,         FREE,   '{1,1,0,0,32'h100,32'hDEAD_BEEF,32'h2002_0001,32'h11,0});
    tbl[10] = row(1,1,1,0, 32'h40,32'h100, 32'hDEAD_BEEF, 32'h22,        ACCESS, '{0,1,1,0,32'h40,32'hDEAD_BEEF,32'h22,32'h11,0});
    tbl[11] = row(1,0,0,0, 32'h40,32'h100, 32'hDEAD_BEEF, 32'h0,         FREE,   '{0,0,0,0,32'h40,32'hDEAD_BEEF,32'h22,32'h11,0});

    foreach (tbl[i]) begin
      nRST = tbl[i].nrst; iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
      iaddr = tbl[i].ia; daddr = tbl[i].da; dstore = tbl[i].ds; ramload = tbl[i].rl;
      ramstate = tbl[i].rs;
      #1;
      chk($sformatf("vec%0d", i), 200'(actual()), 200'(tbl[i].exp));
      tick();
    end

    // Alternation under continuous contention: completions must go D,I,D,I...
    reset_cycle();
    dREN = 1; iREN = 1; dWEN = 0; ramstate = ACCESS;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      ramload = $urandom;
      #1;
      if (!dwait || !iwait) begin
        dtype = !dwait;
        chk($sformatf("alt%0d", n), 200'(dtype), 200'((n % 2) == 0));
        n++;
      end
      tick();
    end
    chk("alt_count", 200'(n), 200'(8));

    // Watchdog: data read stuck BUSY aborts after TO stalled cycles.
    iREN = 0; dREN = 1; daddr = 32'h200; ramstate = BUSY;
    tick();
    for (int k = 0; k < TO; k++) begin
      #1;
      chk($sformatf("wd_ren%0d", k), 200'(ramREN), 200'(1));
      chk($sformatf("wd_terr%0d", k), 200'(timeout_err), 200'(0));
      tick();
    end
    #1;
    chk("wd_idle_ren", 200'(ramREN), 200'(0));
    chk("wd_terr", 200'(timeout_err), 200'(1));
    chk("wd_dwait", 200'(dwait), 200'(1));
    dREN = 0;
    tick();

    // Reset in the middle of a write clears the port and all sticky state.
    dWEN = 1; daddr = 32'h300; dstore = 32'h0000_CAFE;
    tick();
    #1;
    chk("rst_pre_wen", 200'(ramWEN), 200'(1));
    nRST = 0;
    tick();
    nRST = 1; dWEN = 0;
    #1;
    chk("rst_wen", 200'(ramWEN), 200'(0));
    chk("rst_iload", 200'(iload), 200'(0));
    chk("rst_dload", 200'(dload), 200'(0));
    chk("rst_terr", 200'(timeout_err), 200'(0));
    tick();

    // Requester withdraws one cycle after grant.
    dREN = 1; ramstate = BUSY;
    tick();
    dREN = 0;
    #1;
    chk("drop_dwait0", 200'(dwait), 200'(0));
    tick();
    #1;
    chk("drop_ren", 200'(ramREN), 200'(0));
    chk("drop_dwait1", 200'(dwait), 200'(0));
    tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      int r;
      nRST = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) dWEN = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) iaddr = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 2) == 0) daddr = {$urandom_range(0, 255), 2'b00};
      dstore = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 8) ? FREE : ERROR;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted transaction waits for RAM ACCESS before abort.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, synchronous, active-low.
REQ-004 iREN  in  1  instruction read request from caches; iaddr  in  32  instruction address.
REQ-005 dREN  in  1  data read request; dWEN  in  1  data write request; daddr  in  32  data address; dstore  in  32  write data.
REQ-006 iwait  out  1  high while instruction request is unserviced; iload  out  32  instruction read data.
REQ-007 dwait  out  1  high while data request is unserviced; dload  out  32  data read data.
REQ-008 ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32: RAM request port.
REQ-009 ramload  in  32  RAM read data; ramstate  in  2  RAM status (FREE, BUSY, ACCESS, ERROR).
REQ-010 timeout_err  out  1  sticky flag; set on any watchdog abort.

Function
REQ-011 FSM states IDLE, DATA, INSTR; one transaction in flight at most.
REQ-012 IDLE grant: data request (dREN|dWEN) wins over iREN, except when last_was_data=1 and iREN=1, then INSTR wins (alternation, no starvation).
REQ-013 Grant cycle (in IDLE) latches address, store data, and op (write if dWEN, else read) into registers; next state DATA or INSTR.
REQ-014 dWEN and dREN both high: treated as write; read ignored.
REQ-015 In DATA/INSTR: ramaddr/ramstore/ramREN/ramWEN driven from latched registers only; in IDLE ramREN=ramWEN=0, ramaddr/ramstore hold last values.
REQ-016 Completion: in DATA, ramstate==ACCESS -> dwait=0 that same cycle, dload=ramload; in INSTR, ramstate==ACCESS -> iwait=0, iload=ramload; next state IDLE.
REQ-017 iwait=1 whenever iREN=1 and not completing; dwait=1 whenever (dREN|dWEN)=1 and not completing; both 0 when corresponding request low.
REQ-018 Minimum latency: request seen in IDLE cycle N -> earliest wait-low at cycle N+1.
REQ-019 last_was_data set to 1 on DATA completion, 0 on INSTR completion.
REQ-020 ramstate BUSY/FREE: remain in state, waits held high. ramstate ERROR: remain in state, re-present the same request next cycle (retry).
REQ-021 Requester drops request mid-transaction (dREN=dWEN=0 in DATA, or iREN=0 in INSTR): next state IDLE, ram request deasserted next cycle, no completion.
REQ-022 Watchdog: 8-bit counter cleared on grant, +1 each cycle in DATA/INSTR without ACCESS; reaching TIMEOUT -> IDLE, timeout_err=1, waits stay high (requester sees no completion).
REQ-023 Counter saturates at TIMEOUT; never wraps.
REQ-024 iload/dload hold last completed value when not completing.

Reset
REQ-025 nRST low at a clock edge: state IDLE, last_was_data=0, watchdog=0, timeout_err=0, latched addr/store=0, iload/dload=0.
REQ-026 Reset mid-transaction aborts it; ramREN=ramWEN=0 on the first cycle after reset asserted.

Structure
REQ-027 word_t and ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3) come from cpu_types_pkg; arbiter state enum arb_state_t added to cpu_types_pkg.
REQ-028 Watchdog is one sub-module, arb_watchdog (clear, enable, TIMEOUT parameter, expired output); rest flat.

Verification
REQ-029 iREN=1, iaddr=0x0000_0040, RAM ACCESS after 3 BUSY cycles with ramload=0x2002_0001 -> iwait low exactly cycle 4 after grant, iload=0x2002_0001.
REQ-030 iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD_BEEF) same cycle, last_was_data=0 -> DATA granted, ramWEN=1 ramaddr=0x100 ramstore=0xDEAD_BEEF; after dwait low, INSTR granted next even with dREN still high.
REQ-031 Back-to-back dREN every cycle with iREN held -> grants alternate D,I,D,I; no starvation across 8 transactions.
REQ-032 ramstate held BUSY, TIMEOUT=4 -> abort after 4 cycles, timeout_err=1, dwait remains high, IDLE next.
REQ-033 dREN dropped one cycle after grant -> ramREN=0 next cycle, dwait=0, state IDLE.
REQ-034 nRST low during DATA with ramWEN=1 -> ramWEN=0, iload=dload=0, timeout_err=0 next cycle.
